// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions.
//  - A_* opcode constants for the ALU op field (A_NOP..A_MULU).
//  - FSM state encoding used by the iterative multiplier.
//  - Small helper that tells whether an opcode is a multiply.
package alu_pkg;

  localparam int ALU_OP_W = 5;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t A_NOP  = 5'h00;
  localparam alu_op_t A_ADD  = 5'h01;
  localparam alu_op_t A_ADDU = 5'h02;
  localparam alu_op_t A_SUB  = 5'h03;
  localparam alu_op_t A_SUBU = 5'h04;
  localparam alu_op_t A_AND  = 5'h05;
  localparam alu_op_t A_OR   = 5'h06;
  localparam alu_op_t A_XOR  = 5'h07;
  localparam alu_op_t A_NOR  = 5'h08;
  localparam alu_op_t A_SLT  = 5'h09;
  localparam alu_op_t A_SLTU = 5'h0a;
  localparam alu_op_t A_MUL  = 5'h0b;
  localparam alu_op_t A_MULU = 5'h0c;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mul_state_e;

  // True for the two opcodes the sequential multiplier accepts.
  function automatic logic is_mul_op(input alu_op_t op);
    return (op == A_MUL) || (op == A_MULU);
  endfunction

endpackage

// File: rtl/mul_ovf_chk.sv
// mul_ovf_chk: combinational overflow check for a 2*WIDTH-bit product.
//  Decides whether the product fits in WIDTH bits.
//  Ports:
//   hi        in  WIDTH  product[2W-1:W]
//   lo        in  WIDTH  product[W-1:0]
//   is_signed in  1      1: two's complement product, 0: unsigned product
//   overflow  out 1      product not representable in WIDTH bits
module mul_ovf_chk #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic             is_signed,
  output logic             overflow
);

  // Signed: the high half must be a pure sign extension of lo's MSB.
  // Unsigned: any set bit in the high half is lost.
  always_comb begin
    overflow = 1'b0;
    if (is_signed) begin
      overflow = (hi != {WIDTH{lo[WIDTH-1]}});
    end else begin
      overflow = |hi;
    end
  end

endmodule

// File: rtl/seq_mul_ovf.sv
// seq_mul_ovf: iterative shift-add multiplier (A_MUL signed, A_MULU unsigned)
//  with overflow detection, placed beside the ALU. The pipeline stalls while
//  busy is high and resumes on the one-cycle done pulse.
//  Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset (wins over start)
//   start      in   1      request, sampled only in IDLE
//   op         in   OP_W   A_MUL / A_MULU; anything else is rejected
//   a, b       in   WIDTH  multiplicand / multiplier, captured on accepted start
//   busy       out  1      operation in progress
//   done       out  1      one-cycle pulse, results valid from this cycle
//   result_hi  out  WIDTH  product[2W-1:W]
//   result_lo  out  WIDTH  product[W-1:0]
//   overflow   out  1      product does not fit in WIDTH bits
//  Timing: start in cycle 0 -> busy in cycles 1..WIDTH+1 -> done in WIDTH+2.
module seq_mul_ovf
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  mul_state_e         state_r;
  mul_state_e         state_s;

  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               sign_r;
  logic               is_signed_r;

  logic               legal_s;
  logic               signed_op_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               ovf_s;
  logic               busy_s;
  logic               done_s;

  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               ovf_r;

  assign legal_s     = is_mul_op(op);
  assign signed_op_s = (op == A_MUL);

  // Operand magnitudes: signed negatives are negated as unsigned WIDTH-bit
  // values, so the most negative input maps to 2^(W-1) without extension.
  always_comb begin
    mag_a_s = a;
    mag_b_s = b;
    if (signed_op_s && a[WIDTH-1]) begin
      mag_a_s = ~a + ONE_W;
    end else begin
      mag_a_s = a;
    end
    if (signed_op_s && b[WIDTH-1]) begin
      mag_b_s = ~b + ONE_W;
    end else begin
      mag_b_s = b;
    end
  end

  // Final product: restore the sign of the magnitude product.
  always_comb begin
    prod_s = acc_r;
    if (sign_r) begin
      prod_s = ~acc_r + ONE_2W;
    end else begin
      prod_s = acc_r;
    end
  end

  mul_ovf_chk #(
    .WIDTH(WIDTH)
  ) u_ovf_chk (
    .hi       (prod_s[2*WIDTH-1:WIDTH]),
    .lo       (prod_s[WIDTH-1:0]),
    .is_signed(is_signed_r),
    .overflow (ovf_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; illegal opcodes never leave IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && legal_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode: next values of the registered busy/done flags.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = start && legal_s;
        done_s = start && !legal_s;
      end
      RUN: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      FIX: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= '0;
      mcand_r     <= '0;
      mplier_r    <= '0;
      cnt_r       <= '0;
      sign_r      <= 1'b0;
      is_signed_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      hi_r        <= '0;
      lo_r        <= '0;
      ovf_r       <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      case (state_r)
        IDLE: begin
          if (start && legal_s) begin
            acc_r       <= '0;
            mcand_r     <= {{WIDTH{1'b0}}, mag_a_s};
            mplier_r    <= mag_b_s;
            cnt_r       <= '0;
            sign_r      <= signed_op_s && (a[WIDTH-1] ^ b[WIDTH-1]);
            is_signed_r <= signed_op_s;
          end else if (start) begin
            // Rejected opcode: report a clean zero result.
            hi_r  <= '0;
            lo_r  <= '0;
            ovf_r <= 1'b0;
          end else begin
            acc_r <= acc_r;
          end
        end
        RUN: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end else begin
            acc_r <= acc_r;
          end
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r + CNT_W'(1);
        end
        FIX: begin
          hi_r  <= prod_s[2*WIDTH-1:WIDTH];
          lo_r  <= prod_s[WIDTH-1:0];
          ovf_r <= ovf_s;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result_hi = hi_r;
  assign result_lo = lo_r;
  assign overflow  = ovf_r;

endmodule
